uart_tx_arbiter: RTL

//   Shares the single UART transmitter among N byte-stream requesters (N <= 16).
//   - Round-robin grant; a grant is held for a burst of up to MAX_BURST bytes.
//   - Per byte: issues a one-cycle start pulse, then waits for the transmitter's

---
 rtl/uart_pkg.sv | 34 +++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/uart_tx_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, tag nibble and round-robin pick helper
// for the UART transmitter arbiter (uart_tx_arbiter, rr_arbiter).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    TAG      = 3'd1,
    TAG_WAIT = 3'd2,
    LOAD     = 3'd3,
    WAIT     = 3'd4,
    RELEASE  = 3'd5
  } state_e;

  localparam logic [3:0] TAG_NIBBLE = 4'hA;

  // Returns {found, index}: first set bit of valid at or after ptr,
  // wrapping at n. Scanned from the far end so the nearest hit wins.
  function automatic logic [4:0] rr_pick(
    input logic [15:0] valid,
    input logic [3:0]  ptr,
    input int          n
  );
    logic [4:0] r;
    logic [4:0] s;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      s = {1'b0, ptr} + 5'(i);
      if (s >= 5'(n)) s = s - 5'(n);
      if (i < n && valid[s[3:0]]) r = {1'b1, s[3:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick over N requesters plus the
// registered pointer. Ports: clk, reset (async, active-low), valid_i[N],
// upd_i (advance pointer past upd_idx_i), any_o, pick_o[4].
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] valid_i,
  input  logic         upd_i,
  input  logic [3:0]   upd_idx_i,
  output logic         any_o,
  output logic [3:0]   pick_o
);

  logic [3:0]  ptr_q, ptr_d;
  logic [15:0] valid_ext;
  logic [4:0]  res;

  always_comb begin
    valid_ext = '0;
    valid_ext[N-1:0] = valid_i;
    res = rr_pick(valid_ext, ptr_q, N);
  end

  assign any_o  = res[4];
  assign pick_o = res[3:0];

  always_comb begin
    ptr_d = ptr_q;
    if (upd_i) begin
      ptr_d = (upd_idx_i == 4'(N - 1)) ? 4'd0 : upd_idx_i + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among N byte requesters,
// round-robin, bursts of up to MAX_BURST bytes per grant.
// Ports: clk, reset (async, active-low), req_valid[N], req_data[8N],
// req_ready[N], tx_start, tx_data[8], tx_done, grant_id[4], busy.
// Option: define UART_ARB_TAG_EN to prefix each grant with {4'hA, id}.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N         = 4,
  parameter int MAX_BURST = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_data,
  output logic [N-1:0]   req_ready,
  output logic           tx_start,
  output logic [7:0]     tx_data,
  input  logic           tx_done,
  output logic [3:0]     grant_id,
  output logic           busy
);

  state_e       state_q, state_d;
  logic [3:0]   grant_q, grant_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [7:0]   data_q, data_d;
  logic         start_q, start_d;
  logic [15:0]  valid_ext;
  logic [127:0] data_ext;
  logic         any;
  logic [3:0]   pick;
  logic         own_valid;

  rr_arbiter #(.N(N)) u_rr (
    .clk       (clk),
    .reset     (reset),
    .valid_i   (req_valid),
    .upd_i     (state_q == RELEASE),
    .upd_idx_i (grant_q),
    .any_o     (any),
    .pick_o    (pick)
  );

  // Widen to 16 lanes so the 4-bit grant indexes without width games.
  always_comb begin
    valid_ext = '0;
    valid_ext[N-1:0] = req_valid;
    data_ext = '0;
    data_ext[8*N-1:0] = req_data;
  end

  assign own_valid = valid_ext[grant_q];

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    start_d   = 1'b0;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          grant_d = pick;
          cnt_d   = '0;
`ifdef UART_ARB_TAG_EN
          state_d = TAG;
`else
          state_d = LOAD;
`endif
        end
      end
`ifdef UART_ARB_TAG_EN
      TAG: begin
        data_d  = {TAG_NIBBLE, grant_q};
        start_d = 1'b1;
        state_d = TAG_WAIT;
      end
      TAG_WAIT: begin
        if (tx_done) state_d = LOAD;
      end
`endif
      LOAD: begin
        if (own_valid) begin
          for (int i = 0; i < N; i++) begin
            req_ready[i] = (grant_q == 4'(i));
          end
          data_d  = data_ext[{grant_q, 3'b000} +: 8];
          start_d = 1'b1;
          cnt_d   = cnt_q + 8'd1;
          state_d = WAIT;
        end else begin
          state_d = RELEASE;
        end
      end
      WAIT: begin
        if (tx_done) begin
          state_d = (cnt_q == 8'(MAX_BURST)) ? RELEASE : LOAD;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      start_q <= start_d;
    end
  end

  assign tx_start = start_q;
  assign tx_data  = data_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != IDLE) && (state_q != RELEASE);

endmodule
